mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and shared-bus signals around mem_arbiter.
// The master view is the arbiter itself; the slave view is its environment.
interface mem_arbiter_if;
    logic        if_ce_i;
    logic [31:0] if_addr_i;
    logic [31:0] if_data_o;
    logic        if_ready_o;

    logic        d_ce_i;
    logic        d_we_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_ready_o;

    logic        bus_cyc_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i;
    logic        bus_ack_i;

    logic        err_o;
    logic        stallreq_o;

    modport master (
        input  if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        input  bus_data_i, bus_ack_i,
        output if_data_o, if_ready_o, d_data_o, d_ready_o,
        output bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        output err_o, stallreq_o
    );

    modport slave (
        output if_ce_i, if_addr_i, d_ce_i, d_we_i, d_sel_i, d_addr_i, d_data_i,
        output bus_data_i, bus_ack_i,
        input  if_data_o, if_ready_o, d_data_o, d_ready_o,
        input  bus_cyc_o, bus_we_o, bus_sel_o, bus_addr_o, bus_data_o,
        input  err_o, stallreq_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data requests onto one shared bus, with
// instruction-starvation protection and an access timeout.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master mb
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_D = 2'd1,
        GNT_I = 2'd2
    } state_t;

    localparam logic [2:0] STARVE_MAX  = 3'(STARVE_LIMIT);
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    state_t     state_next;
    logic [2:0] starve_cnt;
    logic [7:0] wait_cnt;
    logic       completing;
    logic       grant_d;
    logic       grant_i;
    logic       ack_hit;
    logic       timeout_hit;

    // No grant is made while a ready pulse is out, so a held ce is re-sampled first.
    assign completing = mb.if_ready_o | mb.d_ready_o;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= 3'd0;
            wait_cnt   <= 8'd0;
        end else begin
            state <= state_next;

            if (grant_i || !mb.if_ce_i) begin
                starve_cnt <= 3'd0;
            end else if (grant_d && (starve_cnt < STARVE_MAX)) begin
                starve_cnt <= starve_cnt + 3'd1;
            end

            if (grant_d || grant_i) begin
                wait_cnt <= 8'd0;
            end else if ((state != IDLE) && !ack_hit && !timeout_hit) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next = GNT_D;
                end else if (grant_i) begin
                    state_next = GNT_I;
                end
            end
            GNT_D, GNT_I: begin
                if (ack_hit || timeout_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        grant_d     = 1'b0;
        grant_i     = 1'b0;
        ack_hit     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (!completing) begin
                    if (mb.d_ce_i && ((starve_cnt < STARVE_MAX) || !mb.if_ce_i)) begin
                        grant_d = 1'b1;
                    end else if (mb.if_ce_i) begin
                        grant_i = 1'b1;
                    end
                end
            end
            GNT_D, GNT_I: begin
                ack_hit     = mb.bus_ack_i;
                timeout_hit = !mb.bus_ack_i && ((wait_cnt + 8'd1) == TIMEOUT_CNT);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mb.bus_cyc_o  <= 1'b0;
            mb.bus_we_o   <= 1'b0;
            mb.bus_sel_o  <= 4'd0;
            mb.bus_addr_o <= 32'd0;
            mb.bus_data_o <= 32'd0;
            mb.if_data_o  <= 32'd0;
            mb.if_ready_o <= 1'b0;
            mb.d_data_o   <= 32'd0;
            mb.d_ready_o  <= 1'b0;
            mb.err_o      <= 1'b0;
        end else begin
            mb.if_ready_o <= 1'b0;
            mb.d_ready_o  <= 1'b0;
            mb.err_o      <= 1'b0;

            if (grant_d) begin
                mb.bus_cyc_o  <= 1'b1;
                mb.bus_we_o   <= mb.d_we_i;
                mb.bus_sel_o  <= mb.d_sel_i;
                mb.bus_addr_o <= mb.d_addr_i;
                mb.bus_data_o <= mb.d_we_i ? mb.d_data_i : 32'd0;
            end else if (grant_i) begin
                mb.bus_cyc_o  <= 1'b1;
                mb.bus_we_o   <= 1'b0;
                mb.bus_sel_o  <= 4'b1111;
                mb.bus_addr_o <= mb.if_addr_i;
                mb.bus_data_o <= 32'd0;
            end else if (ack_hit || timeout_hit) begin
                mb.bus_cyc_o  <= 1'b0;
                mb.bus_we_o   <= 1'b0;
                mb.bus_sel_o  <= 4'd0;
                mb.bus_addr_o <= 32'd0;
                mb.bus_data_o <= 32'd0;
            end

            if (ack_hit) begin
                if (state == GNT_I) begin
                    mb.if_data_o  <= mb.bus_data_i;
                    mb.if_ready_o <= 1'b1;
                end else begin
                    if (!mb.bus_we_o) begin
                        mb.d_data_o <= mb.bus_data_i;
                    end
                    mb.d_ready_o <= 1'b1;
                end
            end else if (timeout_hit) begin
                mb.err_o <= 1'b1;
                if (state == GNT_I) begin
                    mb.if_data_o  <= 32'd0;
                    mb.if_ready_o <= 1'b1;
                end else begin
                    mb.d_data_o  <= 32'd0;
                    mb.d_ready_o <= 1'b1;
                end
            end
        end
    end

    // Held low during reset so every output reads 0 while rst is asserted.
    assign mb.stallreq_o = rst & ((mb.if_ce_i & ~mb.if_ready_o) | (mb.d_ce_i & ~mb.d_ready_o));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester tasks push expected responses,
// a negedge monitor pops and compares on every ready pulse.
module tb_mem_arbiter;
    typedef struct {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    logic        ack_enable = 1'b1;
    logic        spurious_ack = 1'b0;
    logic        prev_cyc = 1'b0;
    int          grant_cyc = 0;
    int          issue_cyc = 0;
    logic [31:0] grant_log[$];
    resp_t       exp_i[$];
    resp_t       exp_d[$];

    mem_arbiter_if m();

    mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(255)) dut (
        .clk(clk),
        .rst(rst),
        .mb (m)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Bus slave: acks in the first bus cycle when enabled; data derived from address.
    always @(negedge clk) begin
        m.bus_ack_i = spurious_ack | (ack_enable & m.bus_cyc_o);
        if (!ack_enable) m.bus_data_i = 32'hDEADDEAD;
        else if (m.bus_addr_o == 32'h100) m.bus_data_i = 32'h3C010101;
        else m.bus_data_i = {m.bus_addr_o[15:0], 16'hBEEF};
    end

    // Response monitor.
    always @(negedge clk) begin
        resp_t e;
        if (m.bus_cyc_o && !prev_cyc) begin
            grant_log.push_back(m.bus_addr_o);
            grant_cyc = cyc;
        end
        prev_cyc = m.bus_cyc_o;
        if (m.if_ready_o) begin
            if (exp_i.size() == 0) begin
                checks++; fails++;
                $display("FAIL if_unexpected_ready: got if_ready_o=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                e = exp_i.pop_front();
                check("if_data", m.if_data_o, e.data);
                check("if_err", 32'(m.err_o), 32'(e.err));
            end
        end
        if (m.d_ready_o) begin
            if (exp_d.size() == 0) begin
                checks++; fails++;
                $display("FAIL d_unexpected_ready: got d_ready_o=1, expected no pulse (cycle %0d)", cyc);
            end else begin
                e = exp_d.pop_front();
                check("d_data", m.d_data_o, e.data);
                check("d_err", 32'(m.err_o), 32'(e.err));
                if (e.err) check("timeout_latency", 32'(cyc - grant_cyc), 32'd255);
            end
        end
        if (m.err_o && !m.if_ready_o && !m.d_ready_o) begin
            checks++; fails++;
            $display("FAIL err_without_ready: got err_o=1 with no ready, expected none (cycle %0d)", cyc);
        end
    end

    task automatic d_access(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_data, input logic exp_err);
        bit seen = 0;
        exp_d.push_back('{data: exp_data, err: exp_err});
        m.d_ce_i = 1'b1; m.d_we_i = we; m.d_sel_i = sel; m.d_addr_i = addr; m.d_data_i = wdata;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (m.d_ready_o) seen = 1;
        end
        check("d_ready_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        m.d_ce_i = 1'b0;
    endtask

    task automatic i_fetch(input logic [31:0] addr, input logic [31:0] exp_data);
        bit seen = 0;
        exp_i.push_back('{data: exp_data, err: 1'b0});
        m.if_ce_i = 1'b1; m.if_addr_i = addr;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (m.if_ready_o) seen = 1;
        end
        check("if_ready_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        m.if_ce_i = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_grants[10];
        exp_grants = '{32'h4000, 32'h4004, 32'h4008, 32'h400C, 32'h2000,
                       32'h4010, 32'h4014, 32'h4018, 32'h401C, 32'h2004};
        m.if_ce_i = 0; m.if_addr_i = 0; m.d_ce_i = 0; m.d_we_i = 0; m.d_sel_i = 0;
        m.d_addr_i = 0; m.d_data_i = 0; m.bus_ack_i = 0; m.bus_data_i = 0;
        #1 rst = 1'b0;
        m.if_ce_i = 1'b1;
        @(negedge clk);
        check("rst_bus_cyc", 32'(m.bus_cyc_o), 32'd0);
        check("rst_if_ready", 32'(m.if_ready_o), 32'd0);
        check("rst_d_ready", 32'(m.d_ready_o), 32'd0);
        check("rst_err", 32'(m.err_o), 32'd0);
        check("rst_stallreq", 32'(m.stallreq_o), 32'd0);
        check("rst_if_data", m.if_data_o, 32'd0);
        m.if_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Instruction read: latency, bus fields, stall request.
        exp_i.push_back('{data: 32'h3C010101, err: 1'b0});
        m.if_ce_i = 1'b1; m.if_addr_i = 32'h100;
        issue_cyc = cyc;
        @(negedge clk);
        check("stall_idle", 32'(m.stallreq_o), 32'd1);
        @(negedge clk);
        check("i_bus_cyc", 32'(m.bus_cyc_o), 32'd1);
        check("i_bus_addr", m.bus_addr_o, 32'h100);
        check("i_bus_sel", 32'(m.bus_sel_o), 32'hF);
        check("i_bus_we", 32'(m.bus_we_o), 32'd0);
        check("stall_grant", 32'(m.stallreq_o), 32'd1);
        @(negedge clk);
        check("if_ready_pulse", 32'(m.if_ready_o), 32'd1);
        check("if_latency", 32'(cyc - issue_cyc), 32'd2);
        check("stall_ready", 32'(m.stallreq_o), 32'd0);
        @(posedge clk); #1;
        m.if_ce_i = 1'b0;
        repeat (3) @(negedge clk);
        check("if_ready_one_cycle", 32'(m.if_ready_o), 32'd0);
        check("if_data_hold", m.if_data_o, 32'h3C010101);
        @(posedge clk); #1;

        // Data read then data write.
        d_access(1'b0, 4'hF, 32'h4000, 32'd0, 32'h4000BEEF, 1'b0);
        fork
            d_access(1'b1, 4'b0011, 32'h4200, 32'h1234ABCD, 32'h4000BEEF, 1'b0);
            begin
                for (int n = 0; n < 10; n++) begin
                    @(negedge clk);
                    if (m.bus_cyc_o) break;
                end
                check("w_bus_we", 32'(m.bus_we_o), 32'd1);
                check("w_bus_sel", 32'(m.bus_sel_o), 32'b0011);
                check("w_bus_data", m.bus_data_o, 32'h1234ABCD);
                check("w_bus_addr", m.bus_addr_o, 32'h4200);
            end
        join
        check("w_d_data_unchanged", m.d_data_o, 32'h4000BEEF);

        // Ack while idle must be ignored.
        spurious_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_no_cyc", 32'(m.bus_cyc_o), 32'd0);
        end
        spurious_ack = 1'b0;
        @(posedge clk); #1;

        // Both requesting continuously: 4 data grants, then 1 instruction grant.
        grant_log.delete();
        fork
            for (int k = 0; k < 8; k++)
                d_access(1'b0, 4'hF, 32'h4000 + 32'(4 * k), 32'd0,
                         {16'h4000 + 16'(4 * k), 16'hBEEF}, 1'b0);
            for (int k = 0; k < 2; k++)
                i_fetch(32'h2000 + 32'(4 * k), {16'h2000 + 16'(4 * k), 16'hBEEF});
        join
        check("starve_grant_count", 32'(grant_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < grant_log.size(); k++)
            check($sformatf("starve_grant_%0d", k), grant_log[k], exp_grants[k]);

        // Timeout on a data read.
        ack_enable = 1'b0;
        d_access(1'b0, 4'hF, 32'h4300, 32'd0, 32'd0, 1'b1);
        ack_enable = 1'b1;
        check("timeout_d_data", m.d_data_o, 32'd0);
        @(posedge clk); #1;

        // Reset asserted mid data grant.
        ack_enable = 1'b0;
        m.d_ce_i = 1'b1; m.d_we_i = 1'b0; m.d_sel_i = 4'hF; m.d_addr_i = 32'h4400;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (m.bus_cyc_o) break;
        end
        check("pre_rst_bus_cyc", 32'(m.bus_cyc_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("rst_mid_bus_cyc", 32'(m.bus_cyc_o), 32'd0);
        m.d_ce_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_mid_d_ready", 32'(m.d_ready_o), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        ack_enable = 1'b1;
        @(posedge clk); #1;
        d_access(1'b0, 4'hF, 32'h4500, 32'd0, 32'h4500BEEF, 1'b0);

        repeat (3) @(posedge clk);
        check("exp_i_drained", 32'(exp_i.size()), 32'd0);
        check("exp_d_drained", 32'(exp_d.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
